// File: rtl/crypto_ctrl_engine.sv
// Instruction controller for the crypto coprocessor: decodes {op, addr, data} against a
// register file, returns READ results and dispatches START commands to an external engine.
module crypto_ctrl_engine #(
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2+ADDR_W+DATA_W-1:0] instr,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       engine_start,
  output logic                       engine_abort,
  output logic [DATA_W-1:0]          engine_operand,
  output logic [DATA_W-1:0]          engine_key,
  input  logic [DATA_W-1:0]          engine_result,
  input  logic                       engine_done,
  output logic                       busy,
  output logic                       err_addr,
  output logic                       err_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpStart = 2'b11;

  typedef enum logic [1:0] {StIdle, StOutHold, StEngWait} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] out_data_q, operand_q, key_q;
  logic              out_valid_q, start_q, abort_q, err_addr_q, err_timeout_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] dest_q;

  logic [1:0]        op;
  logic [ADDR_W-1:0] addr, key_idx;
  logic [DATA_W-1:0] data;
  logic              accept, addr_ok, key_ok, instr_ok, timeout_hit;

  assign op          = instr[DATA_W+ADDR_W +: 2];
  assign addr        = instr[DATA_W +: ADDR_W];
  assign data        = instr[DATA_W-1:0];
  assign key_idx     = data[ADDR_W-1:0];
  assign accept      = instr_valid & instr_ready;
  assign addr_ok     = 32'(addr) < NUM_REGS;
  assign key_ok      = 32'(key_idx) < NUM_REGS;
  // The key index only matters for START; other ops carry arbitrary data.
  assign instr_ok    = addr_ok & ((op != OpStart) | key_ok);
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && instr_ok) begin
          if (op == OpRead)       state_d = StOutHold;
          else if (op == OpStart) state_d = StEngWait;
        end
      end
      StOutHold: if (out_ready) state_d = StIdle;
      StEngWait: if (engine_done || timeout_hit) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == StIdle) && !reset;
    busy        = (state_q != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      operand_q     <= '0;
      key_q         <= '0;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
      dest_q        <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && !instr_ok) begin
            err_addr_q <= 1'b1;
          end else if (accept) begin
            case (op)
              OpNop: begin
                if (data[0]) begin
                  err_addr_q    <= 1'b0;
                  err_timeout_q <= 1'b0;
                end
              end
              OpWrite: regs_q[addr] <= data;
              OpRead: begin
                out_data_q  <= regs_q[addr];
                out_valid_q <= 1'b1;
              end
              default: begin
                operand_q <= regs_q[addr];
                key_q     <= regs_q[key_idx];
                start_q   <= 1'b1;
                cnt_q     <= '0;
                dest_q    <= addr;
              end
            endcase
          end
        end
        StOutHold: if (out_ready) out_valid_q <= 1'b0;
        StEngWait: begin
          cnt_q <= cnt_q + 1'b1;
          // A done arriving on the timeout edge still wins.
          if (engine_done) begin
            regs_q[dest_q] <= engine_result;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            abort_q       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign engine_start   = start_q;
  assign engine_abort   = abort_q;
  assign engine_operand = operand_q;
  assign engine_key     = key_q;
  assign err_addr       = err_addr_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_crypto_ctrl_engine.sv
// Randomized bench for crypto_ctrl_engine: a register-file/flag model plus an XOR engine
// with programmable latency, checked instruction by instruction.
module tb_crypto_ctrl_engine;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 12;
  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [2+AW+DW-1:0] instr;
  logic              instr_valid, instr_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_ready;
  logic              engine_start, engine_abort;
  logic [DW-1:0]     engine_operand, engine_key, engine_result;
  logic              engine_done, busy, err_addr, err_timeout;

  crypto_ctrl_engine #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_REGS(NR),
    .TIMEOUT (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .engine_start  (engine_start),
    .engine_abort  (engine_abort),
    .engine_operand(engine_operand),
    .engine_key    (engine_key),
    .engine_result (engine_result),
    .engine_done   (engine_done),
    .busy          (busy),
    .err_addr      (err_addr),
    .err_timeout   (err_timeout)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [DW-1:0] mregs [NR];
  bit          merr_addr, merr_to;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_flags(input string tag);
    check_eq({tag, "_err_addr"}, err_addr, merr_addr);
    check_eq({tag, "_err_to"}, err_timeout, merr_to);
  endtask

  // Presents one instruction for exactly one accept edge; returns #1 after that edge.
  task automatic send(input logic [1:0] op, input int a, input logic [DW-1:0] d);
    logic [AW-1:0] a4;
    a4 = AW'(a);
    @(negedge clock);
    instr         = {op, a4, d};
    instr_valid   = 1'b1;
    engine_done   = 1'($urandom);
    engine_result = rnd64();
    check_eq("ready_before_accept", instr_ready, 1'b1);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_nop(input int a, input logic [DW-1:0] d);
    send(2'b00, a, d);
    if (a >= NR) merr_addr = 1'b1;
    else if (d[0]) begin
      merr_addr = 1'b0;
      merr_to   = 1'b0;
    end
    check_flags("nop");
    check_eq("nop_busy", busy, 1'b0);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    send(2'b01, a, d);
    if (a >= NR) merr_addr = 1'b1;
    else mregs[a] = d;
    check_flags("wr");
    check_eq("wr_busy", busy, 1'b0);
  endtask

  task automatic do_read(input int a, input int hold);
    out_ready = (hold == 0);
    send(2'b10, a, rnd64());
    if (a >= NR) begin
      merr_addr = 1'b1;
      check_eq("rd_bad_valid", out_valid, 1'b0);
      check_eq("rd_bad_busy", busy, 1'b0);
      check_flags("rd_bad");
      out_ready = 1'b0;
      return;
    end
    check_eq("rd_valid", out_valid, 1'b1);
    check_eq("rd_data", out_data, mregs[a]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check_eq("rd_hold_valid", out_valid, 1'b1);
      check_eq("rd_hold_data", out_data, mregs[a]);
      check_eq("rd_hold_ready", instr_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rd_release_valid", out_valid, 1'b0);
    check_eq("rd_release_ready", instr_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  // lat: cycles after the start cycle before the XOR engine raises done; < 0 means never.
  task automatic do_start(input int a, input int k, input int lat);
    logic [DW-1:0] d, res, op_exp, key_exp;
    bit            ok;
    d      = rnd64();
    d[3:0] = 4'(k);
    send(2'b11, a, d);
    if (a >= NR || k >= NR) begin
      merr_addr = 1'b1;
      check_eq("st_bad_start", engine_start, 1'b0);
      check_eq("st_bad_busy", busy, 1'b0);
      check_flags("st_bad");
      return;
    end
    op_exp  = mregs[a];
    key_exp = mregs[k];
    res     = op_exp ^ key_exp;
    ok      = (lat >= 0) && (lat <= TO - 1);
    check_eq("st_busy0", busy, 1'b1);
    for (int cyc = 0; cyc < TO; cyc++) begin
      engine_done   = (cyc == lat);
      engine_result = res;
      check_eq("st_pulse", engine_start, cyc == 0);
      check_eq("st_operand", engine_operand, op_exp);
      check_eq("st_key", engine_key, key_exp);
      @(posedge clock);
      #1;
      engine_done = 1'b0;
      if (ok && cyc == lat) begin
        mregs[a] = res;
        check_eq("st_done_busy", busy, 1'b0);
        check_eq("st_done_abort", engine_abort, 1'b0);
        break;
      end else if (!ok && cyc + 1 == TO) begin
        merr_to = 1'b1;
        check_eq("st_to_abort", engine_abort, 1'b1);
        check_eq("st_to_busy", busy, 1'b0);
        break;
      end
      check_eq("st_wait_busy", busy, 1'b1);
      check_eq("st_wait_abort", engine_abort, 1'b0);
    end
    check_flags("st_end");
    @(posedge clock);
    #1;
    check_eq("st_abort_cleared", engine_abort, 1'b0);
  endtask

  initial begin
    int r, a, k, lat;
    reset         = 1'b1;
    instr         = '0;
    instr_valid   = 1'b0;
    out_ready     = 1'b0;
    engine_done   = 1'b0;
    engine_result = '0;
    merr_addr     = 1'b0;
    merr_to       = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_ready", instr_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_start", engine_start, 1'b0);
    check_flags("rst");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("post_rst_ready", instr_ready, 1'b1);

    // Directed scenarios.
    do_write(8, 64'd12);
    do_write(10, 64'd4);
    do_read(8, 0);
    do_read(10, 0);
    do_start(8, 10, 3);
    do_read(8, 0);
    do_read(10, 5);
    do_start(8, 10, -1);
    do_read(8, 0);
    do_nop(0, 64'd1);
    do_write(13, 64'd5);
    do_nop(1, 64'd1);
    do_start(2, 14, 3);
    do_start(3, 10, 0);
    do_start(4, 8, TO - 1);
    do_nop(NR + 1, 64'd1);
    do_nop(0, 64'd3);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      if (r == 0) do_nop(a, rnd64());
      else if (r <= 4) do_write(a, rnd64());
      else if (r <= 7) do_read(a, $urandom_range(0, 3));
      else begin
        k = $urandom_range(0, 13);
        case ($urandom_range(0, 4))
          0:       lat = -1;
          1:       lat = TO - 1;
          2:       lat = 0;
          default: lat = $urandom_range(0, 6);
        endcase
        do_start(a % 14, k, lat);
      end
    end

    // Reset while waiting on the engine; a late done must be ignored.
    do_write(3, rnd64());
    do_write(4, rnd64());
    send(2'b11, 3, 64'd4);
    engine_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_mid_busy", busy, 1'b1);
    @(negedge clock);
    reset       = 1'b1;
    engine_done = 1'b1;
    @(posedge clock);
    #1;
    engine_done = 1'b0;
    check_eq("rst_mid_busy_low", busy, 1'b0);
    check_eq("rst_mid_ready", instr_ready, 1'b0);
    check_eq("rst_mid_abort", engine_abort, 1'b0);
    check_eq("rst_mid_operand", engine_operand, '0);
    check_eq("rst_mid_key", engine_key, '0);
    check_eq("rst_mid_out_valid", out_valid, 1'b0);
    merr_addr = 1'b0;
    merr_to   = 1'b0;
    check_flags("rst_mid");
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    @(negedge clock);
    reset         = 1'b0;
    engine_done   = 1'b1;
    engine_result = rnd64();
    @(posedge clock);
    #1;
    engine_done = 1'b0;
    check_eq("after_rst_busy", busy, 1'b0);
    check_eq("after_rst_ready", instr_ready, 1'b1);
    check_eq("after_rst_abort", engine_abort, 1'b0);
    for (int i = 0; i < NR; i++) do_read(i, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
